// File: rtl/qz_tracker.sv
// qz_tracker: observes the upstream {Q1,Q0} state and Z output, counts non-overlapping
// SEQ0..SEQ3 matches and, with QZ_TRACKER_ZRUN_EN defined, tracks current/longest Z=1 runs.
module qz_tracker #(
  parameter int unsigned CW   = 8,
  parameter logic [1:0]  SEQ0 = 2'b11,
  parameter logic [1:0]  SEQ1 = 2'b10,
  parameter logic [1:0]  SEQ2 = 2'b00,
  parameter logic [1:0]  SEQ3 = 2'b01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          Q0,
  input  logic          Q1,
  input  logic          Z,
  output logic [1:0]    sym_last,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] zrun,
  output logic [CW-1:0] zmax
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [1:0]    sym;
  logic [1:0]    restart;
  logic [1:0]    state_q, state_d;
  logic [1:0]    sym_last_q, sym_last_d;
  logic          match_q, match_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;

  assign sym     = {Q1, Q0};
  // A broken sequence may itself be the start of a new one.
  assign restart = (sym == SEQ0) ? S1 : S0;

  always_comb begin
    state_d     = state_q;
    sym_last_d  = sym_last_q;
    match_d     = 1'b0;
    match_cnt_d = match_cnt_q;
    if (en) begin
      sym_last_d = sym;
      case (state_q)
        S0:      state_d = restart;
        S1:      state_d = (sym == SEQ1) ? S2 : restart;
        S2:      state_d = (sym == SEQ2) ? S3 : restart;
        default: begin
          if (sym == SEQ3) begin
            state_d = S0;
            match_d = 1'b1;
            if (match_cnt_q != CntMax) match_cnt_d = match_cnt_q + CntOne;
          end else begin
            state_d = restart;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S0;
      sym_last_q  <= 2'b00;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sym_last_q  <= sym_last_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign sym_last  = sym_last_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;

`ifdef QZ_TRACKER_ZRUN_EN
  logic [CW-1:0] zrun_q, zrun_d;
  logic [CW-1:0] zmax_q, zmax_d;
  logic [CW-1:0] zrun_inc;

  assign zrun_inc = (zrun_q == CntMax) ? zrun_q : zrun_q + CntOne;

  always_comb begin
    zrun_d = zrun_q;
    zmax_d = zmax_q;
    if (en) begin
      if (Z) begin
        zrun_d = zrun_inc;
        if (zrun_inc > zmax_q) zmax_d = zrun_inc;
      end else begin
        zrun_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zrun_q <= '0;
      zmax_q <= '0;
    end else begin
      zrun_q <= zrun_d;
      zmax_q <= zmax_d;
    end
  end

  assign zrun = zrun_q;
  assign zmax = zmax_q;
`else
  logic unused_z;
  assign unused_z = Z;
  assign zrun     = '0;
  assign zmax     = '0;
`endif

endmodule

// File: tb/tb_qz_tracker.sv
// Randomized bench for qz_tracker: CW=8 and CW=2 instances share stimulus and are
// compared each cycle against a queue-based model of the sequence and Z-run rules.
module tb_qz_tracker;

  logic       clk = 1'b0;
  logic       rst, en, q0, q1, z;
  logic [1:0] sym_last_a, sym_last_b;
  logic       match_a, match_b;
  logic [7:0] cnt_a, zrun_a, zmax_a;
  logic [1:0] cnt_b, zrun_b, zmax_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] seq_arr [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  // Reference model state: symbols of the partial match, unbounded counts.
  int          part_q [$];
  int unsigned m_cnt, m_run, m_max;
  logic [1:0]  m_last;
  bit          m_match;

  always #5 clk = ~clk;

  qz_tracker #(.CW(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .Q0(q0), .Q1(q1), .Z(z),
    .sym_last(sym_last_a), .match(match_a), .match_cnt(cnt_a), .zrun(zrun_a), .zmax(zmax_a)
  );

  qz_tracker #(.CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .Q0(q0), .Q1(q1), .Z(z),
    .sym_last(sym_last_b), .match(match_b), .match_cnt(cnt_b), .zrun(zrun_b), .zmax(zmax_b)
  );

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input logic [1:0] s, input bit zz);
    if (r) begin
      part_q.delete();
      m_cnt = 0; m_run = 0; m_max = 0; m_last = 2'b00; m_match = 1'b0;
    end else if (e) begin
      m_last  = s;
      m_match = 1'b0;
      if (s == seq_arr[part_q.size()]) begin
        part_q.push_back(int'(s));
        if (part_q.size() == 4) begin
          m_match = 1'b1;
          m_cnt++;
          part_q.delete();
        end
      end else begin
        part_q.delete();
        if (s == seq_arr[0]) part_q.push_back(int'(s));
      end
      if (zz) begin
        m_run++;
        if (m_run > m_max) m_max = m_run;
      end else begin
        m_run = 0;
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic check_all();
    int unsigned ez8, em8, ez2, em2;
`ifdef QZ_TRACKER_ZRUN_EN
    ez8 = sat(m_run, 255); em8 = sat(m_max, 255);
    ez2 = sat(m_run, 3);   em2 = sat(m_max, 3);
`else
    ez8 = 0; em8 = 0; ez2 = 0; em2 = 0;
`endif
    check_eq("sym_last8", 32'(sym_last_a), 32'(m_last));
    check_eq("match8",    32'(match_a),    32'(m_match));
    check_eq("cnt8",      32'(cnt_a),      sat(m_cnt, 255));
    check_eq("zrun8",     32'(zrun_a),     ez8);
    check_eq("zmax8",     32'(zmax_a),     em8);
    check_eq("sym_last2", 32'(sym_last_b), 32'(m_last));
    check_eq("match2",    32'(match_b),    32'(m_match));
    check_eq("cnt2",      32'(cnt_b),      sat(m_cnt, 3));
    check_eq("zrun2",     32'(zrun_b),     ez2);
    check_eq("zmax2",     32'(zmax_b),     em2);
  endtask

  // Drive one cycle, advance the model at the edge, check 1 time unit later.
  task automatic step(input bit r, input bit e, input logic [1:0] s, input bit zz);
    rst = r; en = e; {q1, q0} = s; z = zz;
    @(posedge clk);
    model_update(r, e, s, zz);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    int idx;
    logic [1:0] s;
    rst = 1'b1; en = 1'b0; q0 = 1'b0; q1 = 1'b0; z = 1'b0;
    m_cnt = 0; m_run = 0; m_max = 0; m_last = 2'b00; m_match = 1'b0;

    do_reset();
    do_reset();

    // Plain sequence 11,10,00,01.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_arr[i], 1'b0);
    check_eq("tp1_match", 32'(match_a), 32'd1);
    check_eq("tp1_cnt", 32'(cnt_a), 32'd1);
    check_eq("tp1_last", 32'(sym_last_a), 32'd1);
    step(1'b0, 1'b1, 2'b10, 1'b0);
    check_eq("tp1_pulse_end", 32'(match_a), 32'd0);

    // Restart on mismatch: 11,10,11,10,00,01.
    do_reset();
    step(1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_arr[i], 1'b0);
    check_eq("tp2_cnt", 32'(cnt_a), 32'd1);

    // Enable gap mid-sequence.
    do_reset();
    step(1'b0, 1'b1, 2'b11, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'(i), 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0);
    check_eq("tp3_match", 32'(match_a), 32'd1);

    // Reset mid-sequence discards the partial match.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, seq_arr[i], 1'b1);
    do_reset();
    step(1'b0, 1'b1, 2'b01, 1'b0);
    check_eq("tp4_match", 32'(match_a), 32'd0);
    check_eq("tp4_cnt", 32'(cnt_a), 32'd0);

    // Z pattern 1,1,1,0,1,1.
    do_reset();
    foreach (seq_arr[i]) begin end
    step(1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b1);

    // Five sequences: CW=2 count saturates at 3.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, seq_arr[i % 4], 1'b0);
    check_eq("tp6_cnt2", 32'(cnt_b), 32'd3);
    check_eq("tp6_cnt8", 32'(cnt_a), 32'd5);

    // Randomized traffic biased toward the target sequence.
    idx = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 2'($urandom_range(0, 3));
      end else begin
        s = seq_arr[idx];
        idx = (idx + 1) % 4;
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), s,
           ($urandom_range(0, 3) != 0));
    end

    // Saturate the 8-bit counters.
    do_reset();
    for (int i = 0; i < 1040; i++) step(1'b0, 1'b1, seq_arr[i % 4], 1'b1);
    check_eq("sat_cnt8", 32'(cnt_a), 32'd255);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_arr[i], 1'b1);
    check_eq("sat_match8", 32'(match_a), 32'd1);
    check_eq("sat_cnt8_hold", 32'(cnt_a), 32'd255);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
